// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin arbiter sharing one single-ported memory between two requesters
module mem_port_arbiter #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0,
   input  logic              we0,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [DATA_W-1:0] wdata0,
   input  logic              req1,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              done0,
   output logic              done1,
   output logic [DATA_W-1:0] rdata,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_t;

   state_t             state, state_d;
   logic               ptr, ptr_d;
   logic               owner, owner_d;
   logic               win;
   logic               gnt0_d, gnt1_d, done0_d, done1_d;
   logic               mem_read_d, mem_write_d;
   logic [ADDR_W-1:0]  mem_addr_d;
   logic [DATA_W-1:0]  mem_wdata_d, rdata_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         ptr       <= 1'b0;
         owner     <= 1'b0;
         gnt0      <= 1'b0;
         gnt1      <= 1'b0;
         done0     <= 1'b0;
         done1     <= 1'b0;
         mem_read  <= 1'b0;
         mem_write <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         rdata     <= '0;
      end else begin
         state     <= state_d;
         ptr       <= ptr_d;
         owner     <= owner_d;
         gnt0      <= gnt0_d;
         gnt1      <= gnt1_d;
         done0     <= done0_d;
         done1     <= done1_d;
         mem_read  <= mem_read_d;
         mem_write <= mem_write_d;
         mem_addr  <= mem_addr_d;
         mem_wdata <= mem_wdata_d;
         rdata     <= rdata_d;
      end
   end

   always_comb begin
      state_d     = state;
      ptr_d       = ptr;
      owner_d     = owner;
      gnt0_d      = gnt0;
      gnt1_d      = gnt1;
      done0_d     = done0;
      done1_d     = done1;
      mem_read_d  = mem_read;
      mem_write_d = mem_write;
      mem_addr_d  = mem_addr;
      mem_wdata_d = mem_wdata;
      rdata_d     = rdata;
      // a lone requester always wins; the pointer only breaks ties
      win         = (req0 && req1) ? ptr : req1;

      case (state)
         IDLE: begin
            if (req0 || req1) begin
               owner_d     = win;
               gnt0_d      = ~win;
               gnt1_d      = win;
               mem_write_d = win ? we1 : we0;
               mem_read_d  = win ? ~we1 : ~we0;
               mem_addr_d  = win ? addr1 : addr0;
               mem_wdata_d = win ? wdata1 : wdata0;
               state_d     = ACCESS;
            end
         end
         ACCESS: begin
            if (mem_read) rdata_d = mem_rdata;
            mem_read_d  = 1'b0;
            mem_write_d = 1'b0;
            done0_d     = ~owner;
            done1_d     = owner;
            state_d     = DONE;
         end
         DONE: begin
            gnt0_d  = 1'b0;
            gnt1_d  = 1'b0;
            done0_d = 1'b0;
            done1_d = 1'b0;
            ptr_d   = ~owner;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter with transaction-level reference model
module tb_mem_port_arbiter;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       req0, we0, req1, we1;
   logic [7:0] addr0, wdata0, addr1, wdata1;
   logic       gnt0, gnt1, done0, done1;
   logic [7:0] rdata;
   logic       mem_read, mem_write;
   logic [7:0] mem_addr, mem_wdata, mem_rdata;

   logic [7:0] mem     [256];
   logic [7:0] ref_mem [256];
   logic       ref_ptr;
   logic [7:0] ref_rdata;
   int         n_cmp = 0;
   int         n_err = 0;

   mem_port_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
      .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
      .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
      .rdata(rdata), .mem_read(mem_read), .mem_write(mem_write),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   assign mem_rdata = mem[mem_addr];
   always @(posedge clk) if (mem_write) mem[mem_addr] <= mem_wdata;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic quiet();
      req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
      req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
   endtask

   task automatic test_reset();
      rst_n = 0;
      quiet();
      tick(); tick();
      if ({gnt0, gnt1, done0, done1, mem_read, mem_write, mem_addr, mem_wdata, rdata} !== 30'd0) begin
         $display("FAIL reset_outputs: got %h want 0", {gnt0, gnt1, done0, done1, mem_read, mem_write, mem_addr, mem_wdata, rdata}); n_err++;
      end
      n_cmp++;
      rst_n = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         if ({gnt0, gnt1} !== 2'b00) begin $display("FAIL reset_idle_gnt: got %b want 00", {gnt0, gnt1}); n_err++; end
         n_cmp++;
      end
      req0 = 1; addr0 = 8'h33;
      tick();
      if (gnt0 !== 1'b1) begin $display("FAIL reset_pre_gnt: got %b want 1", gnt0); n_err++; end
      n_cmp++;
      #2 rst_n = 0;
      #1;
      if ({gnt0, gnt1, done0, mem_read, mem_addr} !== 12'd0) begin
         $display("FAIL reset_async: got %h want 0", {gnt0, gnt1, done0, mem_read, mem_addr}); n_err++;
      end
      n_cmp++;
      quiet();
      tick();
      rst_n = 1;
      ref_ptr = 0; ref_rdata = 0;
   endtask

   task automatic test_write_read();
      req0 = 1; we0 = 1; addr0 = 8'h10; wdata0 = 8'hA5;
      tick();
      if ({gnt0, gnt1, mem_write, mem_read, mem_addr, mem_wdata, done0} !== {4'b1010, 8'h10, 8'hA5, 1'b0}) begin
         $display("FAIL wr_grant: got %h want %h", {gnt0, gnt1, mem_write, mem_read, mem_addr, mem_wdata, done0}, {4'b1010, 8'h10, 8'hA5, 1'b0}); n_err++;
      end
      n_cmp++;
      req0 = 0;
      tick();
      if ({done0, done1, gnt0, mem_write} !== 4'b1010) begin $display("FAIL wr_done: got %b want 1010", {done0, done1, gnt0, mem_write}); n_err++; end
      n_cmp++;
      tick();
      if ({done0, gnt0} !== 2'b00) begin $display("FAIL wr_release: got %b want 00", {done0, gnt0}); n_err++; end
      n_cmp++;
      ref_mem[8'h10] = 8'hA5; ref_ptr = 1;
      req0 = 1; we0 = 0;
      tick();
      if ({gnt0, mem_read, mem_write} !== 3'b110) begin $display("FAIL rd_grant: got %b want 110", {gnt0, mem_read, mem_write}); n_err++; end
      n_cmp++;
      req0 = 0;
      tick();
      if (done0 !== 1'b1 || rdata !== 8'hA5) begin $display("FAIL rd_data: got done=%b rdata=%h want 1 a5", done0, rdata); n_err++; end
      n_cmp++;
      ref_rdata = 8'hA5;
      tick();
   endtask

   task automatic test_simultaneous();
      logic w;
      rst_n = 0; tick(); rst_n = 1;
      ref_ptr = 0;
      req0 = 1; we0 = 0; addr0 = 8'h10;
      req1 = 1; we1 = 0; addr1 = 8'($urandom_range(0, 255));
      for (int k = 0; k < 4; k++) begin
         w = ref_ptr;
         tick();
         if ({gnt0, gnt1} !== {~w, w} || gnt1 !== k[0]) begin
            $display("FAIL sim_gnt%0d: got %b want %b", k, {gnt0, gnt1}, {~w, w}); n_err++;
         end
         n_cmp++;
         tick();
         if ({done0, done1} !== {~w, w} || rdata !== ref_mem[w ? addr1 : addr0]) begin
            $display("FAIL sim_done%0d: got done=%b rdata=%h want %b %h", k, {done0, done1}, rdata, {~w, w}, ref_mem[w ? addr1 : addr0]); n_err++;
         end
         n_cmp++;
         ref_rdata = ref_mem[w ? addr1 : addr0];
         tick();
         if ({done0, done1, gnt0, gnt1} !== 4'b0000) begin $display("FAIL sim_end%0d: got %b want 0000", k, {done0, done1, gnt0, gnt1}); n_err++; end
         n_cmp++;
         ref_ptr = ~w;
      end
      quiet();
      tick();
   endtask

   task automatic test_inflight_change();
      logic [7:0] v;
      v = 8'($urandom_range(1, 255));
      req1 = 1; we1 = 1; addr1 = 8'hFF; wdata1 = v;
      tick(); req1 = 0; tick(); tick();
      ref_mem[8'hFF] = v; ref_ptr = 0;
      req1 = 1; we1 = 0;
      tick();
      if ({gnt1, mem_addr} !== {1'b1, 8'hFF}) begin $display("FAIL inflight_addr: got %h want 1ff", {gnt1, mem_addr}); n_err++; end
      n_cmp++;
      req1 = 0; addr1 = 8'h00; we1 = 1; wdata1 = ~v;
      #3;
      if ({mem_addr, mem_read, mem_write} !== {8'hFF, 2'b10}) begin
         $display("FAIL inflight_hold: got %h want %h", {mem_addr, mem_read, mem_write}, {8'hFF, 2'b10}); n_err++;
      end
      n_cmp++;
      tick();
      if (done1 !== 1'b1 || rdata !== ref_mem[8'hFF]) begin $display("FAIL inflight_rdata: got done=%b %h want 1 %h", done1, rdata, ref_mem[8'hFF]); n_err++; end
      n_cmp++;
      ref_rdata = v;
      tick();
      if (mem[8'h00] !== ref_mem[8'h00]) begin $display("FAIL inflight_nowrite: got %h want %h", mem[8'h00], ref_mem[8'h00]); n_err++; end
      n_cmp++;
      quiet();
   endtask

   task automatic test_reset_during_access();
      req0 = 1; addr0 = 8'h10;
      tick(); req0 = 0; tick(); tick();
      req1 = 1; we1 = 1; addr1 = 8'h20; wdata1 = 8'h3C;
      tick();
      if ({gnt1, mem_write} !== 2'b11) begin $display("FAIL rst_acc_start: got %b want 11", {gnt1, mem_write}); n_err++; end
      n_cmp++;
      #2 rst_n = 0;
      #1;
      if ({mem_write, gnt1, done1} !== 3'b000) begin $display("FAIL rst_acc_drop: got %b want 000", {mem_write, gnt1, done1}); n_err++; end
      n_cmp++;
      quiet();
      tick(); tick();
      if (done1 !== 1'b0 || mem[8'h20] !== 8'h00) begin $display("FAIL rst_acc_nocommit: got done1=%b mem=%h want 0 00", done1, mem[8'h20]); n_err++; end
      n_cmp++;
      rst_n = 1;
      ref_ptr = 0; ref_rdata = 0;
      req0 = 1; req1 = 1; addr0 = 8'h00; addr1 = 8'h10;
      tick();
      if ({gnt0, gnt1} !== 2'b10) begin $display("FAIL rst_acc_ptr: got %b want 10", {gnt0, gnt1}); n_err++; end
      n_cmp++;
      quiet();
      tick(); tick();
      ref_ptr = 1;
   endtask

   task automatic test_back_to_back();
      int cnt;
      int pos [$];
      cnt = 0;
      req0 = 1; we0 = 0; addr0 = 8'h00;
      for (int i = 1; i <= 9; i++) begin
         tick();
         if (done0 === 1'b1) begin
            cnt++;
            pos.push_back(i);
            if (rdata !== 8'h00) begin $display("FAIL b2b_rdata: got %h want 00", rdata); n_err++; end
            n_cmp++;
         end
      end
      req0 = 0;
      if (cnt !== 3) begin $display("FAIL b2b_count: got %0d want 3", cnt); n_err++; end
      n_cmp++;
      if (cnt == 3) begin
         if (pos[1] - pos[0] !== 3 || pos[2] - pos[1] !== 3) begin
            $display("FAIL b2b_spacing: got %0d,%0d want 3,3", pos[1] - pos[0], pos[2] - pos[1]); n_err++;
         end
         n_cmp++;
      end
      tick();
      if ({gnt0, gnt1} !== 2'b00) begin $display("FAIL b2b_stop: got %b want 00", {gnt0, gnt1}); n_err++; end
      n_cmp++;
      ref_ptr = 1;
   endtask

   task automatic test_random();
      int         pat;
      logic       w, wwe;
      logic [7:0] wa, wd;
      rst_n = 0; tick(); rst_n = 1;
      ref_ptr = 0; ref_rdata = 0;
      for (int r = 0; r < 40; r++) begin
         pat = $urandom_range(1, 3);
         req0 = pat[0]; req1 = pat[1];
         we0 = 1'($urandom); we1 = 1'($urandom);
         addr0 = 8'($urandom); addr1 = 8'($urandom);
         wdata0 = 8'($urandom); wdata1 = 8'($urandom);
         w   = (pat == 3) ? ref_ptr : (pat == 2);
         wwe = w ? we1 : we0;
         wa  = w ? addr1 : addr0;
         wd  = w ? wdata1 : wdata0;
         tick();
         if ({gnt0, gnt1, mem_write, mem_read, mem_addr} !== {~w, w, wwe, ~wwe, wa} || (wwe && mem_wdata !== wd)) begin
            $display("FAIL rnd_grant%0d: got %h want %h", r, {gnt0, gnt1, mem_write, mem_read, mem_addr, mem_wdata}, {~w, w, wwe, ~wwe, wa, wd}); n_err++;
         end
         n_cmp++;
         req0 = 1'($urandom); req1 = 1'($urandom); we0 = 1'($urandom); we1 = 1'($urandom);
         addr0 = 8'($urandom); addr1 = 8'($urandom); wdata0 = 8'($urandom); wdata1 = 8'($urandom);
         if (wwe) ref_mem[wa] = wd;
         else     ref_rdata = ref_mem[wa];
         tick();
         if ({done0, done1, mem_read, mem_write} !== {~w, w, 2'b00} || rdata !== ref_rdata) begin
            $display("FAIL rnd_done%0d: got done=%b rw=%b rdata=%h want %b 00 %h", r, {done0, done1}, {mem_read, mem_write}, rdata, {~w, w}, ref_rdata); n_err++;
         end
         n_cmp++;
         tick();
         if ({gnt0, gnt1, done0, done1} !== 4'b0000) begin $display("FAIL rnd_end%0d: got %b want 0000", r, {gnt0, gnt1, done0, done1}); n_err++; end
         n_cmp++;
         ref_ptr = ~w;
      end
      quiet();
      tick();
      for (int a = 0; a < 256; a++) begin
         if (mem[a] !== ref_mem[a]) begin $display("FAIL rnd_mem: addr %0d got %h want %h", a, mem[a], ref_mem[a]); n_err++; end
         n_cmp++;
      end
   endtask

   initial begin
      for (int a = 0; a < 256; a++) begin
         mem[a]     = 8'h00;
         ref_mem[a] = 8'h00;
      end
      ref_ptr = 0; ref_rdata = 0;
      test_reset();
      test_write_read();
      test_simultaneous();
      test_inflight_change();
      test_reset_during_access();
      test_back_to_back();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
